// File: rtl/regfile_32x32_wr.sv
// MIPS general-purpose register file: r0 hard-wired to zero, two combinational read
// ports with optional write forwarding, one write port, debug port, saturating write counter.
module regfile_32x32_wr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R_addr_A,
  input  logic [ADDR_W-1:0] R_addr_B,
  input  logic [ADDR_W-1:0] Wt_addr,
  input  logic [DATA_W-1:0] Wt_data,
  input  logic              L_S,
  output logic [DATA_W-1:0] rdata_A,
  output logic [DATA_W-1:0] rdata_B,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [1:NREG-1];
  logic [DATA_W-1:0] read_view [NREG];
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              wr_req;
  logic              wr_commit;
  logic              byp_a;
  logic              byp_b;

  // Forwarding ignores rst; the commit itself is suppressed by rst.
  assign wr_req    = L_S && (Wt_addr != '0);
  assign wr_commit = wr_req && !rst;

  assign read_view[0] = '0;

  // Per-register address decode keeps an unknown enable confined to the addressed register.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (wr_commit && (Wt_addr == ADDR_W'(gi))) begin
          regs_reg[gi] <= Wt_data;
        end
      end
      assign read_view[gi] = regs_reg[gi];
    end
  endgenerate

  assign byp_a = (BYPASS != 0) && wr_req && (R_addr_A == Wt_addr);
  assign byp_b = (BYPASS != 0) && wr_req && (R_addr_B == Wt_addr);

  assign rdata_A  = byp_a ? Wt_data : read_view[R_addr_A];
  assign rdata_B  = byp_b ? Wt_data : read_view[R_addr_B];
  assign dbg_data = read_view[dbg_addr];

  always_comb begin
    cnt_next = cnt_reg;
    if (wr_commit && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign wr_cnt = cnt_reg;

endmodule

// File: tb/tb_regfile_32x32_wr.sv
// Bench for regfile_32x32_wr: a forwarding instance and a non-forwarding 4-bit-counter
// instance share stimulus; table vectors, corner sequences, then randomized model checks.
module tb_regfile_32x32_wr;

  logic        clk;
  logic        rst;
  logic [4:0]  R_addr_A;
  logic [4:0]  R_addr_B;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;
  logic        L_S;
  logic [4:0]  dbg_addr;
  logic [31:0] rdata_A_b, rdata_B_b, dbg_data_b;
  logic [31:0] rdata_A_n, rdata_B_n, dbg_data_n;
  logic [15:0] wr_cnt_b;
  logic [3:0]  wr_cnt_n;

  int n_vec = 0;
  int n_err = 0;

  regfile_32x32_wr #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(16)) u_byp (
    .clk(clk), .rst(rst), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .Wt_addr(Wt_addr), .Wt_data(Wt_data), .L_S(L_S),
    .rdata_A(rdata_A_b), .rdata_B(rdata_B_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .wr_cnt(wr_cnt_b)
  );

  regfile_32x32_wr #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) u_nob (
    .clk(clk), .rst(rst), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .Wt_addr(Wt_addr), .Wt_data(Wt_data), .L_S(L_S),
    .rdata_A(rdata_A_n), .rdata_B(rdata_B_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_n), .wr_cnt(wr_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ls;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  dbg;
    logic [31:0] exp_a_b;
    logic [31:0] exp_b_b;
    logic [31:0] exp_a_n;
    logic [31:0] exp_b_n;
    logic [31:0] exp_dbg;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [8];

  // Reference model: plain array of register contents plus an unbounded write tally.
  logic [31:0] m_regs [32];
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ls, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dbg);
    rst = r; L_S = ls; Wt_addr = wa; Wt_data = wd;
    R_addr_A = ra; R_addr_B = rb; dbg_addr = dbg;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : m_regs[a];
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    logic        r_r, r_ls;
    logic [4:0]  r_wa, r_ra, r_rb, r_dbg;
    logic [31:0] r_wd, e_ab, e_bb;

    //            rst  ls  wa     wd             ra     rb     dbg    a_byp          b_byp          a_nob          b_nob          dbg            cnt
    vecs[0] = '{1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd9,  5'd8,  5'd8,  32'h0,         32'hDEADBEEF, 32'h0,         32'h0,         32'h0,         1};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  5'd8,  32'hDEADBEEF, 32'h0,         32'hDEADBEEF, 32'h0,         32'hDEADBEEF, 1};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         1};
    vecs[3] = '{1'b0, 1'b1, 5'd3,  32'h11111111, 5'd0,  5'd8,  5'd3,  32'h0,         32'hDEADBEEF, 32'h0,         32'hDEADBEEF, 32'h0,         2};
    vecs[4] = '{1'b0, 1'b1, 5'd3,  32'h22222222, 5'd3,  5'd3,  5'd3,  32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111, 32'h11111111, 3};
    vecs[5] = '{1'b0, 1'b1, 5'd7,  32'h00000077, 5'd3,  5'd7,  5'd3,  32'h22222222, 32'h00000077, 32'h22222222, 32'h0,         32'h22222222, 4};
    vecs[6] = '{1'b1, 1'b1, 5'd7,  32'hAAAA5555, 5'd7,  5'd3,  5'd7,  32'hAAAA5555, 32'h22222222, 32'h00000077, 32'h22222222, 32'h00000077, 0};
    vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd3,  5'd8,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0};

    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    edge_settle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Every address reads zero on every port after reset.
    for (int a = 0; a < 32; a++) begin
      R_addr_A = 5'(a); R_addr_B = 5'(31 - a); dbg_addr = 5'(a);
      #1;
      check("reset_rdA_byp", rdata_A_b, 32'h0);
      check("reset_rdB_byp", rdata_B_b, 32'h0);
      check("reset_dbg_byp", dbg_data_b, 32'h0);
      check("reset_rdA_nob", rdata_A_n, 32'h0);
      check("reset_dbg_nob", dbg_data_n, 32'h0);
    end
    check("reset_cnt_byp", 32'(wr_cnt_b), 32'h0);
    check("reset_cnt_nob", 32'(wr_cnt_n), 32'h0);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst, vecs[i].ls, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, vecs[i].dbg);
      #1;
      check("tbl_rdA_byp", rdata_A_b, vecs[i].exp_a_b);
      check("tbl_rdB_byp", rdata_B_b, vecs[i].exp_b_b);
      check("tbl_rdA_nob", rdata_A_n, vecs[i].exp_a_n);
      check("tbl_rdB_nob", rdata_B_n, vecs[i].exp_b_n);
      check("tbl_dbg_byp", dbg_data_b, vecs[i].exp_dbg);
      check("tbl_dbg_nob", dbg_data_n, vecs[i].exp_dbg);
      edge_settle();
      check("tbl_cnt_byp", 32'(wr_cnt_b), 32'(vecs[i].exp_cnt));
      check("tbl_cnt_nob", 32'(wr_cnt_n), 32'(vecs[i].exp_cnt));
      $display("vec %0d: rst=%0b ls=%0b wa=%0d wd=%08h ra=%0d rb=%0d cnt=%0d",
               i, vecs[i].rst, vecs[i].ls, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, wr_cnt_b);
    end

    // Post-reset view of r7 after a reset that collided with a write to r7.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    #1;
    check("rst_mid_r7_A", rdata_A_b, 32'h0);
    check("rst_mid_r7_dbg", dbg_data_n, 32'h0);

    // Counter saturation: 20 committed writes to r1..r20.
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'hC0DE0000 + 32'(i), 5'd0, 5'd0, 5'd0);
      edge_settle();
      check("sat_cnt_nob", 32'(wr_cnt_n), 32'(sat(i, 15)));
      check("sat_cnt_byp", 32'(wr_cnt_b), 32'(i));
      $display("sat write %0d: cnt4=%0h cnt16=%0d", i, wr_cnt_n, wr_cnt_b);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd1, 5'd20);
    #1;
    check("sat_r20_A", rdata_A_n, 32'hC0DE0014);
    check("sat_r1_B", rdata_B_n, 32'hC0DE0001);
    check("sat_r20_dbg", dbg_data_b, 32'hC0DE0014);

    // Randomized phase against the array model; start from a known reset.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    edge_settle();
    for (int a = 0; a < 32; a++) m_regs[a] = 32'h0;
    m_cnt = 0;

    for (int t = 0; t < 400; t++) begin
      r_r   = ($urandom_range(0, 39) == 0);
      r_ls  = ($urandom_range(0, 3) != 0);
      r_wa  = 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      r_rb  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      r_dbg = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      drive(r_r, r_ls, r_wa, r_wd, r_ra, r_rb, r_dbg);
      #1;
      e_ab = (r_ls && r_wa != 0 && r_ra == r_wa) ? r_wd : model_read(r_ra);
      e_bb = (r_ls && r_wa != 0 && r_rb == r_wa) ? r_wd : model_read(r_rb);
      check("rnd_rdA_byp", rdata_A_b, e_ab);
      check("rnd_rdB_byp", rdata_B_b, e_bb);
      check("rnd_rdA_nob", rdata_A_n, model_read(r_ra));
      check("rnd_rdB_nob", rdata_B_n, model_read(r_rb));
      check("rnd_dbg_byp", dbg_data_b, model_read(r_dbg));
      check("rnd_dbg_nob", dbg_data_n, model_read(r_dbg));
      edge_settle();
      if (r_r) begin
        for (int a = 0; a < 32; a++) m_regs[a] = 32'h0;
        m_cnt = 0;
      end else if (r_ls && r_wa != 0) begin
        m_regs[r_wa] = r_wd;
        m_cnt++;
      end
      check("rnd_cnt_byp", 32'(wr_cnt_b), 32'(sat(m_cnt, 65535)));
      check("rnd_cnt_nob", 32'(wr_cnt_n), 32'(sat(m_cnt, 15)));
      $display("rnd %0d: rst=%0b ls=%0b wa=%0d wd=%08h ra=%0d rb=%0d dbg=%0d cnt=%0d",
               t, r_r, r_ls, r_wa, r_wd, r_ra, r_rb, r_dbg, wr_cnt_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_32x32_wr.md
Name: regfile_32x32_wr

Overview:
- MIPS general-purpose register file: 32 registers of 32 bits, two asynchronous read ports and one synchronous write port.
- The write address is the 5-bit destination produced by the datapath's register-destination 2:1 selector (rt or rd). This block is that selector's consumer: it decodes the address and commits the write-back data.
- Also provides a debug read port for the board display, plus a saturating write counter.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; register count = 2**ADDR_W.
- BYPASS, 1, when 1 a same-cycle write to the address being read is forwarded to that read port.
- CNT_W, 16, width of the write counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- R_addr_A  input  ADDR_W  read port A address (rs).
- R_addr_B  input  ADDR_W  read port B address (rt).
- Wt_addr  input  ADDR_W  write address (output of the register-destination selector).
- Wt_data  input  DATA_W  write-back data.
- L_S  input  1  write enable (RegWrite).
- rdata_A  output  DATA_W  read port A data.
- rdata_B  output  DATA_W  read port B data.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data; never bypassed.
- wr_cnt  output  CNT_W  count of committed writes.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Storage:
  - Registers 1..31 are flops.
  - Register 0 is not stored; every read of address 0 returns 0 on all three ports.
- Reset:
  - On a rising clk edge with rst=1, registers 1..31 become 0 and wr_cnt becomes 0.
  - Any write presented in that same cycle is discarded, and wr_cnt does not increment.
  - Reset takes effect only at the edge: during the rst=1 cycle, reads still return the pre-reset contents (BYPASS still applies).
  - After the edge, rdata_A, rdata_B and dbg_data all read 0.
- Write:
  - On a rising clk edge with rst=0 and L_S=1 and Wt_addr!=0, reg[Wt_addr] <= Wt_data.
  - Visible to non-bypassed reads from the next cycle onward (1-cycle latency).
  - A write to address 0 changes nothing.
- wr_cnt:
  - Increments by 1 on each committed write, i.e. rst=0, L_S=1, Wt_addr!=0.
  - Saturates at all-ones: no wrap to 0.
- Read:
  - rdata_A, rdata_B and dbg_data are purely combinational from their addresses and storage (0-cycle latency).
  - An address change propagates within the same cycle.
- Bypass:
  - Applies when BYPASS=1, L_S=1, Wt_addr!=0, and R_addr_X==Wt_addr.
  - In that case rdata_X = Wt_data in the same cycle, independent of rst.
  - Otherwise rdata_X = stored value.
  - With BYPASS=0, same-cycle reads return the old value.
- Simultaneous events:
  - A and B may read the same address, and both may bypass at once.
  - Reads never block writes; there is no structural hazard.
- Undefined/X inputs: none are required to be handled; L_S=X must not corrupt registers other than Wt_addr.

Test Plan:
- Reset and r0:
  - Assert rst for 1 cycle, then read addresses 0..31 on A, B and debug -> all 0.
  - wr_cnt = 0.
- Write then read:
  - L_S=1, Wt_addr=5'd8, Wt_data=32'hDEADBEEF, one edge.
  - Then R_addr_A=8 -> rdata_A=32'hDEADBEEF.
  - R_addr_B=9 -> 0.
  - wr_cnt = 1.
- Write to r0:
  - L_S=1, Wt_addr=0, Wt_data=32'hFFFFFFFF, one edge.
  - rdata_A at address 0 = 0.
  - wr_cnt unchanged.
- Bypass:
  - BYPASS=1: with r3=32'h11111111, set R_addr_A=R_addr_B=3, L_S=1, Wt_addr=3, Wt_data=32'h22222222.
  - Before the edge, both ports = 32'h22222222; dbg_data at 3 = 32'h11111111.
  - BYPASS=0 instance with the same stimulus: both ports = 32'h11111111 before the edge, and 32'h22222222 after it.
- Reset mid-operation:
  - r7 = 32'h00000077. Drive rst=1 together with L_S=1, Wt_addr=7, Wt_data=32'hAAAA5555, one edge.
  - After the edge: r7 = 0 and wr_cnt = 0.
- Saturation:
  - CNT_W=4: perform 20 writes to r1..r20.
  - wr_cnt reads 4'hF after the 15th write and stays 4'hF.
  - r20 holds its last written value.
